seven_seg_scan: RTL
===================

Name: seven_seg_scan

Overview:
Time-multiplexed scan controller for a multi-digit seven-segment display. It sits directly upstream of the seven-segment decoder. It presents one 4-bit hex nibble at a time on the decoder's data input, drives the decoder's blanking input, and drives a one-hot digit-select (anode) vector. Display data is captured once per frame into a shadow register so a digit never shows a mix of old and new values.

Parameters:
DIGITS, 4, number of display digits; legal 1..8
CLK_DIV, 50000, clock cycles per digit slot (dwell); legal >= 2
GUARD, 500, anti-ghosting cycles at the end of each slot with all digits off; legal 0..CLK_DIV-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
value  input  4*DIGITS  hex value to display; nibble k goes to digit k, digit 0 = least significant
digit_en  input  DIGITS  per-digit enable mask; 0 = digit always dark
hex_out  output  4  nibble for the decoder data input
dec_en  output  1  goes to the decoder's active-low blank input; 1 = segments lit, 0 = blank
an  output  DIGITS  one-hot digit select, active-high; all-zero = no digit lit
frame_start  output  1  one-cycle pulse when the slot index wraps to 0 and the shadow register reloads

Behaviour:
- Reset: cnt=0, idx=0, shadow=0, hex_out=0, dec_en=0, an=0, frame_start=0, all forced immediately with no clock edge; hold while rst=1.
- Prescaler cnt counts 0..CLK_DIV-1 and wraps. slot_tick is asserted when cnt==CLK_DIV-1.
- Slot index idx advances on slot_tick and wraps from DIGITS-1 to 0.
- Shadow load: on slot_tick with idx==DIGITS-1, shadow <= value. At the same edge frame_start <= 1; it is 0 on every other cycle.
- Visible window is cnt in [0, CLK_DIV-GUARD-1]. Guard window is cnt in [CLK_DIV-GUARD, CLK_DIV-1]. With GUARD=0 there is no guard window.
- Outputs are registered and lag the state by 1 cycle. At each edge:
  - hex_out <= shadow nibble idx. This is always driven, including during guard.
  - lit = visible window AND digit_en[idx], sampled live.
  - an <= lit ? (1<<idx) : 0.
  - dec_en <= lit.
- an is never more than one-hot. an=0 whenever dec_en=0.
- First frame after reset shows shadow=0, so 0s on enabled digits. The value applied at reset release appears from the second frame on.
- A value change mid-frame has no effect until the next frame wrap.
- A digit_en change takes effect on the next cycle. Slot timing is never altered.
- Reset mid-frame: outputs go to 0 asynchronously. Scan restarts at idx=0, cnt=0 after release.
- Frame period = DIGITS*CLK_DIV cycles, exactly.

Optional Feature:
Macro SEVEN_SEG_SCAN_LZ_BLANK_EN (leading-zero suppression).
- Defined: digit k>0 is forced dark (an=0, dec_en=0) when shadow nibbles k..DIGITS-1 are all zero. Digit 0 is never suppressed by this rule. Suppression combines by AND with digit_en; timing is unchanged.
- Undefined: every enabled digit is shown, including leading zeros.

Test Plan:
(Bench uses DIGITS=4, CLK_DIV=4, GUARD=1, digit_en=4'b1111 unless stated.)
1. Reset: assert rst, value=16'h1A3F -> an=0, dec_en=0, hex_out=0, frame_start=0 immediately. Release -> next cycle an=4'b0001, dec_en=1, hex_out=0; no frame_start pulse for 16 cycles, then a 1-cycle pulse.
2. Scan order: value=16'h1A3F, observe 2nd frame -> hex_out F,3,A,1 with an 0001,0010,0100,1000. Each slot has 3 lit cycles then 1 cycle an=0000, dec_en=0. Frame = 16 cycles.
3. Tear-free: while idx=1 of a frame showing 16'h1A3F, set value=16'h0000 -> slots 2,3 still show A,1. Next frame shows 0,0,0,0.
4. Mask: digit_en=4'b1011 -> during slot 2, an=0000 and dec_en=0 for all 4 cycles. Slots 0,1,3 unchanged; frame still 16 cycles.
5. Async reset mid-frame: pulse rst between edges during slot 2 -> an/dec_en/hex_out go to 0 before the next edge. After release, scan restarts at an=4'b0001.
6. SEVEN_SEG_SCAN_LZ_BLANK_EN defined:
   - value=16'h0050 -> digits 3,2 dark; digit 1 shows 5; digit 0 shows 0.
   - value=16'h0000 -> only digit 0 lit, showing 0.
   - Macro undefined, value=16'h0050 -> all four digits lit.

Source files
------------

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed seven-segment scan controller
// Optional leading-zero suppression: define SEVEN_SEG_SCAN_LZ_BLANK_EN.
module seven_seg_scan #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [3:0]            hex_out,
  output logic                  dec_en,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] VIS_LAST = CW'(CLK_DIV - GUARD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [3:0]            hex_q, hex_d;
  logic                  dec_en_q, dec_en_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  slot_tick;
  logic                  frame_wrap;
  logic                  visible;
  logic [DIGITS-1:0]     lz_ok;

  assign slot_tick  = (cnt_q == CNT_LAST);
  assign frame_wrap = slot_tick & (idx_q == IDX_LAST);
  assign visible    = (cnt_q <= VIS_LAST);

`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
  logic nz_seen;

  // A digit may light if it or any more-significant nibble is nonzero; digit 0 always may.
  always_comb begin
    nz_seen = 1'b0;
    lz_ok   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_seen  = nz_seen | (shadow_q[4*k +: 4] != 4'h0);
      lz_ok[k] = nz_seen | (k == 0);
    end
  end
`else
  assign lz_ok = '1;
`endif

  always_comb begin
    cnt_d    = slot_tick ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    frame_d  = frame_wrap;
    if (slot_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    if (frame_wrap) begin
      shadow_d = value;
    end
  end

  // Outputs lag the scan state by one cycle; digit_en is sampled live.
  always_comb begin
    hex_d    = 4'h0;
    an_d     = '0;
    dec_en_d = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        hex_d    = shadow_q[4*k +: 4];
        dec_en_d = visible & digit_en[k] & lz_ok[k];
        an_d[k]  = visible & digit_en[k] & lz_ok[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      hex_q    <= 4'h0;
      dec_en_q <= 1'b0;
      an_q     <= '0;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
      dec_en_q <= dec_en_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign hex_out     = hex_q;
  assign dec_en      = dec_en_q;
  assign an          = an_q;
  assign frame_start = frame_q;

endmodule
